led_scroller: RTL and testbench

- Upstream feeder for the 4x8 LED matrix driver; produces the four 8-bit column bytes (leds1..leds4) the display multiplexer scans out.
- Holds a pattern buffer of DEPTH bytes, loaded through a valid/ready write port.
- Presents a 4-byte window of that buffer and steps the window one byte per prescaler tick, giving a marquee.
- Window fetch is sequential: one buffer read per cycle, BRAM-friendly. All four outputs update together in one cycle.

---
 rtl/led_scroller_if.sv | 23 ++
 rtl/led_scroller.sv | 119 +++++++++++
 tb/tb_led_scroller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/led_scroller_if.sv
// led_scroller_if: control inputs, pattern write port and LED column outputs of led_scroller.
interface led_scroller_if #(
    parameter int ADDR_W = 4
);
    logic              run;
    logic              dir;
    logic [ADDR_W:0]   len;
    logic              refresh;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        leds1, leds2, leds3, leds4;
    logic              overrun;
    modport master (
        output run, dir, len, refresh, wr_valid, wr_addr, wr_data,
        input  wr_ready, leds1, leds2, leds3, leds4, overrun
    );
    modport slave (
        input  run, dir, len, refresh, wr_valid, wr_addr, wr_data,
        output wr_ready, leds1, leds2, leds3, leds4, overrun
    );
endinterface

// File: rtl/led_scroller.sv
// led_scroller: pattern buffer plus a 4-byte window that steps once per prescaler tick (marquee).
// Define LED_SCROLL_BOUNCE_EN to sweep back and forth between 0 and L-4 instead of wrapping.
module led_scroller #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 1200000
) (
    input logic           clk12MHz,
    input logic           rst_n,
    led_scroller_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]     P_TOP = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]   L_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L1    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A1    = ADDR_W'(1);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, LAST, COMMIT} state_t;
    state_t            r_state, w_next;
    logic [PW-1:0]     r_presc;
    logic [7:0]        r_buf [DEPTH];
    logic [7:0]        r_rd;
    logic [7:0]        r_stage [4];
    logic [7:0]        r_leds [4];
    logic [ADDR_W-1:0] r_pos, r_npos, r_addr, w_pos_eff, w_step_pos, w_addr_inc;
    logic [ADDR_W:0]   r_len, w_len;
    logic              r_pending, r_overrun;
    logic              w_tick, w_idle, w_ready, w_req, w_step, w_wr;
`ifdef LED_SCROLL_BOUNCE_EN
    localparam logic [ADDR_W:0] L4 = (ADDR_W+1)'(4);
    logic            r_bdir, r_nbdir, w_bdir;
    logic [ADDR_W:0] w_end;
`endif
    assign w_tick     = bus.run && r_presc == P_TOP;
    assign w_len      = (bus.len == '0 || bus.len > L_MAX) ? L_MAX : bus.len;
    assign w_pos_eff  = ({1'b0, r_pos} >= w_len) ? '0 : r_pos;
    assign w_step     = w_tick | r_pending;
    assign w_addr_inc = ({1'b0, r_addr} + L1 == r_len) ? '0 : r_addr + A1;
    assign w_wr       = bus.wr_valid & w_ready;
`ifdef LED_SCROLL_BOUNCE_EN
    assign w_end = w_len - L4;
    always_comb begin
        w_step_pos = '0;
        w_bdir     = r_bdir;
        if (w_len > L4) begin
            if (!r_bdir) begin
                w_bdir     = ({1'b0, w_pos_eff} + L1 >= w_end);
                w_step_pos = w_bdir ? w_end[ADDR_W-1:0] : w_pos_eff + A1;
            end else begin
                w_bdir     = (w_pos_eff > A1);
                w_step_pos = w_bdir ? w_pos_eff - A1 : '0;
            end
        end
    end
    always_ff @(posedge clk12MHz) begin
        if (!rst_n) begin
            r_bdir  <= 1'b0;
            r_nbdir <= 1'b0;
        end else if (w_idle && w_req) begin
            r_nbdir <= w_step ? w_bdir : r_bdir;
        end else if (r_state == COMMIT) begin
            r_bdir <= r_nbdir;
        end
    end
`else
    assign w_step_pos = bus.dir
        ? ((w_pos_eff == '0) ? w_len[ADDR_W-1:0] - A1 : w_pos_eff - A1)
        : (({1'b0, w_pos_eff} + L1 == w_len) ? '0 : w_pos_eff + A1);
`endif
    always_ff @(posedge clk12MHz)
        r_state <= rst_n ? w_next : IDLE;
    always_comb
        w_next = (r_state == IDLE) ? (w_req ? RD0 : IDLE)
               : (r_state == COMMIT) ? IDLE : state_t'(r_state + 3'd1);
    always_comb begin
        w_idle  = r_state == IDLE;
        w_ready = w_idle & rst_n;
        w_req   = w_tick | bus.refresh | r_pending;
    end
    // The fetch reads the window at the position it will show; pos itself only moves at COMMIT.
    always_ff @(posedge clk12MHz) begin
        r_rd <= r_buf[r_addr];
        if (w_wr) r_buf[bus.wr_addr] <= bus.wr_data;
        if (r_state inside {RD1, RD2, RD3, LAST}) r_stage[2'(r_state - RD1)] <= r_rd;
        if (!rst_n) begin
            r_presc   <= '0;
            r_pos     <= '0;
            r_npos    <= '0;
            r_addr    <= '0;
            r_len     <= L_MAX;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_leds    <= '{default: '0};
        end else begin
            r_presc <= (!bus.run || w_tick) ? '0 : r_presc + 1'b1;
            if (w_idle) begin
                r_pending <= r_pending & w_tick;
                if (w_req) begin
                    r_len  <= w_len;
                    r_addr <= w_step ? w_step_pos : w_pos_eff;
                    r_npos <= w_step ? w_step_pos : w_pos_eff;
                end
            end else if (w_tick) begin
                r_pending <= 1'b1;
                r_overrun <= r_overrun | r_pending;
            end
            if (r_state inside {RD0, RD1, RD2}) r_addr <= w_addr_inc;
            if (r_state == COMMIT) begin
                r_leds <= r_stage;
                r_pos  <= r_npos;
            end
        end
    end
    assign bus.wr_ready = w_ready;
    assign bus.leds1    = r_leds[0];
    assign bus.leds2    = r_leds[1];
    assign bus.leds3    = r_leds[2];
    assign bus.leds4    = r_leds[3];
    assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_led_scroller.sv
// tb_led_scroller: scoreboard bench for led_scroller; expected windows are queued per request
// and compared each time a fetch commits (wr_ready returns high).
`timescale 1ns/1ps
module tb_led_scroller;
    localparam int DEPTH = 16, ADDR_W = 4, TICK_DIV = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0, n_err = 0;
    logic [31:0] sb_q[$];
    bit          sb_en = 1'b1;
    logic [7:0]  m_buf [DEPTH];
    int          m_pos = 0, m_len = 0, n;
    bit          m_bdir = 1'b0;
    led_scroller_if #(.ADDR_W(ADDR_W)) bus ();
    led_scroller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
        .clk12MHz(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #3;
        end
    endtask
    function automatic logic [31:0] leds();
        return {bus.leds1, bus.leds2, bus.leds3, bus.leds4};
    endfunction
    task automatic model_req(input bit step);
        int l;
        logic [31:0] w;
        l = (m_len == 0 || m_len > DEPTH) ? DEPTH : m_len;
        w = '0;
        if (m_pos >= l) m_pos = 0;
        if (step) begin
`ifdef LED_SCROLL_BOUNCE_EN
            if (l <= 4) m_pos = 0;
            else if (!m_bdir) begin
                m_pos++;
                if (m_pos >= l - 4) begin m_pos = l - 4; m_bdir = 1'b1; end
            end else begin
                m_pos--;
                if (m_pos <= 0) begin m_pos = 0; m_bdir = 1'b0; end
            end
`else
            m_pos = bus.dir ? (m_pos + l - 1) % l : (m_pos + 1) % l;
`endif
        end
        for (int k = 0; k < 4; k++) w = {w[23:0], m_buf[(m_pos + k) % l]};
        sb_q.push_back(w);
    endtask
    task automatic pulse_refresh();
        bus.refresh = 1'b1;
        cyc();
        bus.refresh = 1'b0;
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk(tag, sb_q.size(), 0);
        #1;
    endtask
    task automatic run_steps(input int k);
        for (int i = 0; i < k; i++) model_req(1'b1);
        bus.run = 1'b1;
        drain("steps");
        bus.run = 1'b0;
    endtask
    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'(a);
        bus.wr_data  = d;
        for (int i = 0; i < 50 && !bus.wr_ready; i++) cyc();
        cyc();
        bus.wr_valid = 1'b0;
        m_buf[a] = d;
    endtask
    initial begin
        int low;
        low = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) low = 0;
            else if (!bus.wr_ready) low++;
            else if (low > 0) begin
                if (sb_en) begin
                    chk("busy_len", low, 6);
                    if (sb_q.size() == 0) chk("sb_empty", sb_q.size(), 1);
                    else chk("window", leds(), sb_q.pop_front());
                end
                low = 0;
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.run = 1'b0; bus.dir = 1'b0; bus.len = '0; bus.refresh = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        cyc(3);
        chk("rst_leds", leds(), 0);
        chk("rst_ovr", bus.overrun, 0);
        chk("rst_ready", bus.wr_ready, 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_ready", bus.wr_ready, 1);
        for (int i = 0; i < DEPTH; i++) wr(i, 8'(8'h10 + i));
        model_req(1'b0);
        pulse_refresh();
        chk("busy", bus.wr_ready, 0);
        cyc(4);
        chk("lat_hold", leds(), 0);
        drain("refresh");
        run_steps(14);
        bus.len = 3; m_len = 3; bus.dir = 1'b1;
        model_req(1'b0);
        pulse_refresh();
        drain("len3");
        run_steps(1);
        // write held high across a refresh fetch with a tick landing in RD1
        bus.len = 0; m_len = 0; bus.dir = 1'b0;
        model_req(1'b0);
        m_buf[5] = 8'hA5;
        model_req(1'b1);
        cyc();
        bus.run = 1'b1;
        cyc(5);
        pulse_refresh();
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hA5;
        cyc(2);
        bus.run = 1'b0;
        n = 0;
        while (!bus.wr_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("wr_land", n, 4);
        cyc();
        bus.wr_valid = 1'b0;
        chk("pend_served", bus.wr_ready, 0);
        drain("wr_hold");
        sb_en = 1'b0;
        chk("ovr_clear", bus.overrun, 0);
        for (int i = 0; i < 5; i++) begin
            force dut.w_tick = 1'b1;
            cyc();
            release dut.w_tick;
            cyc(2);
        end
        cyc(30);
        chk("ovr_set", bus.overrun, 1);
        for (int i = 0; i < 50 && !bus.wr_ready; i++) cyc();
        pulse_refresh();
        cyc(2);
        chk("pre_rst_nz", leds() != 0, 1);
        chk("ovr_sticky", bus.overrun, 1);
        rst_n = 1'b0;
        cyc();
        chk("rst_leds2", leds(), 0);
        chk("rst_ovr2", bus.overrun, 0);
        chk("rst_ready2", bus.wr_ready, 0);
        cyc();
        rst_n = 1'b1;
        m_pos = 0; m_bdir = 1'b0;
        cyc();
        sb_en = 1'b1;
        model_req(1'b0);
        pulse_refresh();
        drain("post_rst");
        run_steps(2);
`ifdef LED_SCROLL_BOUNCE_EN
        bus.len = 6; m_len = 6;
        model_req(1'b0);
        pulse_refresh();
        drain("bounce_ref");
        run_steps(6);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
